usb_txn_arbiter: RTL
====================

// Module: usb_txn_arbiter
// PURPOSE
//  Shares the single USB read/write transaction engine (RW_FSM) between NUM_REQ requesters.
//  Round-robin grants one queued read/write request at a time and drives the engine's start/mempage/data inputs.
//  Holds start until the engine reports finished, retries failed or timed-out transactions, returns a per-requester response.
//  Sits between host-side clients (test tasks, DMA) and RW_FSM inside USBHost.
// PARAMETERS
//  NUM_REQ         2     number of requesters, >=2
//  MAX_RETRIES     3     extra attempts after a failed/timed-out attempt (total attempts = MAX_RETRIES+1)
//  TIMEOUT_CYCLES  4096  cycles with start held and no finished before an attempt counts as failed
// PORTS
//  clock             input   1           system clock, all logic on posedge
//  reset             input   1           synchronous, active-high reset
//  req_valid         input   NUM_REQ     request pending per requester; held until req_ready
//  req_is_write      input   NUM_REQ     1=write transaction, 0=read
//  req_mempage       input   NUM_REQ*16  page address per requester
//  req_wdata         input   NUM_REQ*64  write payload per requester (ignored for reads)
//  req_ready         output  NUM_REQ     one-hot, 1-cycle pulse: request latched
//  rsp_valid         output  NUM_REQ     one-hot, 1-cycle pulse: transaction complete
//  rsp_success       output  1           result, qualified by |rsp_valid
//  rsp_rdata         output  64          read data; 0 on writes and on failed reads
//  busy              output  1           1 from grant until response cycle inclusive
//  eng_read_start    output  1           to RW_FSM read_start
//  eng_write_start   output  1           to RW_FSM write_start
//  eng_read_mempage  output  16          to RW_FSM read_mempage
//  eng_write_mempage output  16          to RW_FSM write_mempage
//  eng_write_data    output  64          to RW_FSM write_data
//  eng_finished      input   1           from RW_FSM finished
//  eng_read_success  input   1           from RW_FSM read_success
//  eng_write_success input   1           from RW_FSM write_success
//  eng_read_data     input   64          from RW_FSM read_data
// BEHAVIOUR
//  - All outputs registered. Reset: every output 0, state IDLE, rr pointer 0, retry and timeout counters 0.
//  - States: IDLE -> BUSY -> (GAP -> BUSY)* -> RESP -> IDLE.
//  - IDLE: if |req_valid at edge T, grant g = first set bit at or after pointer (wrapping);
//    req_ready[g]=1 in cycle T+1; latch is_write/mempage/wdata; attempt=0; -> BUSY.
//  - BUSY: exactly one of eng_read_start/eng_write_start =1 (per latched is_write), held every cycle;
//    eng_*_mempage/eng_write_data stable = latched values. Start is high from T+1 (same cycle as req_ready).
//    Timeout counter increments each BUSY cycle, cleared on entry.
//  - Completion: eng_finished sampled 1 -> attempt result = eng_write_success (write) or eng_read_success (read);
//    read data captured same edge. Timeout = counter reaches TIMEOUT_CYCLES without finished -> result 0.
//    finished and timeout in the same cycle: finished wins.
//  - On result 1, or result 0 with attempt==MAX_RETRIES -> RESP. Otherwise attempt++ -> GAP.
//  - GAP: start low for exactly 1 cycle (engine returns to idle), then -> BUSY.
//  - RESP: rsp_valid[g]=1 one cycle, rsp_success=result, rsp_rdata=captured data iff read&&success else 0;
//    pointer <= (g+1) mod NUM_REQ; -> IDLE. New grant earliest on the next cycle.
//  - Requests arriving/changing while busy are ignored until IDLE; req_valid dropping before req_ready is legal.
//  - Reset mid-transaction: start drops at the next edge, no rsp_valid is issued; requester must re-request.
//  - Counters: attempt width $clog2(MAX_RETRIES+1) (min 1), timeout width $clog2(TIMEOUT_CYCLES+1); no wrap.
// STRUCTURE
//  - USBPkg: USB_MEMPAGE_W=16, USB_DATA_W=64, typedef enum txn_arb_state_t {ARB_IDLE, ARB_BUSY, ARB_GAP, ARB_RESP}.
//  - Sub-module rr_arbiter #(N): req vector + pointer -> one-hot grant + index, purely combinational.
//  - Top: FSM, request latch, retry/timeout counters, response register.
// TESTING (bench models RW_FSM: finished after programmable delay, programmable success)
//  1. req0 write page 16'h0010 data 64'hDEADBEEF_CAFEF00D, engine finishes at 50 cycles success ->
//     req_ready=01, eng_write_start high 50 cycles with page 0010, rsp_valid=01, rsp_success=1, rsp_rdata=0.
//  2. req_valid=11 held from reset -> grants 0,1,0,1 in order; each rsp precedes the next req_ready.
//  3. req1 read page 16'h0003, engine fails twice then succeeds with 64'h0123_4567_89AB_CDEF ->
//     3 start pulses with 1-cycle gaps, rsp_valid=10, success=1, rdata=0123_4567_89AB_CDEF.
//  4. TIMEOUT_CYCLES=100, engine never finishes -> 4 attempts of 100 cycles each, rsp_success=0, rdata=0.
//  5. reset at BUSY cycle 10 -> next edge all outputs 0, no rsp_valid; fresh req served normally.
//  6. finished asserted exactly at timeout cycle with success=1 -> no retry, rsp_success=1.

Source files
------------

// File: rtl/usb_txn_arbiter_pkg.sv
// Shared widths, FSM encoding and helpers for the USB transaction arbiter.
package usb_txn_arbiter_pkg;

    localparam int unsigned USB_MEMPAGE_W = 16;
    localparam int unsigned USB_DATA_W    = 64;

    typedef logic [1:0] txn_arb_state_t;

    localparam txn_arb_state_t ARB_IDLE = 2'd0;
    localparam txn_arb_state_t ARB_BUSY = 2'd1;
    localparam txn_arb_state_t ARB_GAP  = 2'd2;
    localparam txn_arb_state_t ARB_RESP = 2'd3;

    // Bits needed to count 0..v-1, never less than one.
    function automatic int unsigned clog2_min1(input int unsigned v);
        return (v <= 2) ? 1 : $clog2(v);
    endfunction

endpackage

// File: rtl/usb_txn_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first requester at or after the pointer, wrapping.
module rr_arbiter #(
    parameter int unsigned N  = 2,
    parameter int unsigned IW = 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx,
    output logic          any
);

    logic [IW-1:0] cand;

    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        cand  = '0;
        for (int unsigned k = 0; k < N; k++) begin
            cand = IW'((32'(ptr) + k) % N);
            if (!any && req[cand]) begin
                any         = 1'b1;
                idx         = cand;
                grant[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/usb_txn_arbiter.sv
// Round-robin sharing of the USB read/write engine with retry, timeout and
// per-requester response reporting.
module usb_txn_arbiter
    import usb_txn_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ        = 2,
    parameter int unsigned MAX_RETRIES    = 3,
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic [NUM_REQ-1:0]                req_valid,
    input  logic [NUM_REQ-1:0]                req_is_write,
    input  logic [NUM_REQ*USB_MEMPAGE_W-1:0]  req_mempage,
    input  logic [NUM_REQ*USB_DATA_W-1:0]     req_wdata,
    output logic [NUM_REQ-1:0]                req_ready,
    output logic [NUM_REQ-1:0]                rsp_valid,
    output logic                              rsp_success,
    output logic [USB_DATA_W-1:0]             rsp_rdata,
    output logic                              busy,
    output logic                              eng_read_start,
    output logic                              eng_write_start,
    output logic [USB_MEMPAGE_W-1:0]          eng_read_mempage,
    output logic [USB_MEMPAGE_W-1:0]          eng_write_mempage,
    output logic [USB_DATA_W-1:0]             eng_write_data,
    input  logic                              eng_finished,
    input  logic                              eng_read_success,
    input  logic                              eng_write_success,
    input  logic [USB_DATA_W-1:0]             eng_read_data
);

    localparam int unsigned IDX_W = clog2_min1(NUM_REQ);
    localparam int unsigned ATT_W = clog2_min1(MAX_RETRIES + 1);
    localparam int unsigned TO_W  = clog2_min1(TIMEOUT_CYCLES + 1);

    txn_arb_state_t     state;
    logic [IDX_W-1:0]   rr_ptr;
    logic [IDX_W-1:0]   gnt_idx;
    logic [NUM_REQ-1:0] gnt_onehot;
    logic               lat_write;
    logic [ATT_W-1:0]   attempt;
    logic [TO_W-1:0]    tcnt;

    logic [NUM_REQ-1:0] arb_grant;
    logic [IDX_W-1:0]   arb_idx;
    logic               arb_any;

    logic [TO_W-1:0]    tcnt_inc;
    logic               attempt_done;
    logic               attempt_ok;
    logic               last_attempt;
    logic [IDX_W-1:0]   ptr_next;

    rr_arbiter #(
        .N  (NUM_REQ),
        .IW (IDX_W)
    ) u_rr (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .grant (arb_grant),
        .idx   (arb_idx),
        .any   (arb_any)
    );

    // Finished beats timeout when both land on the same cycle.
    always_comb begin
        tcnt_inc     = tcnt + TO_W'(1);
        attempt_done = 1'b0;
        attempt_ok   = 1'b0;
        if (eng_finished) begin
            attempt_done = 1'b1;
            attempt_ok   = lat_write ? eng_write_success : eng_read_success;
        end else if (tcnt_inc == TO_W'(TIMEOUT_CYCLES)) begin
            attempt_done = 1'b1;
        end
        last_attempt = (attempt == ATT_W'(MAX_RETRIES));
        ptr_next     = (gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx + IDX_W'(1);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state             <= ARB_IDLE;
            rr_ptr            <= '0;
            gnt_idx           <= '0;
            gnt_onehot        <= '0;
            lat_write         <= 1'b0;
            attempt           <= '0;
            tcnt              <= '0;
            req_ready         <= '0;
            rsp_valid         <= '0;
            rsp_success       <= 1'b0;
            rsp_rdata         <= '0;
            busy              <= 1'b0;
            eng_read_start    <= 1'b0;
            eng_write_start   <= 1'b0;
            eng_read_mempage  <= '0;
            eng_write_mempage <= '0;
            eng_write_data    <= '0;
        end else begin
            req_ready <= '0;
            rsp_valid <= '0;
            case (state)
                ARB_IDLE: begin
                    if (arb_any) begin
                        state             <= ARB_BUSY;
                        req_ready         <= arb_grant;
                        gnt_idx           <= arb_idx;
                        gnt_onehot        <= arb_grant;
                        lat_write         <= req_is_write[arb_idx];
                        attempt           <= '0;
                        tcnt              <= '0;
                        busy              <= 1'b1;
                        eng_read_start    <= ~req_is_write[arb_idx];
                        eng_write_start   <= req_is_write[arb_idx];
                        eng_read_mempage  <=
                            req_mempage[arb_idx*USB_MEMPAGE_W +: USB_MEMPAGE_W];
                        eng_write_mempage <=
                            req_mempage[arb_idx*USB_MEMPAGE_W +: USB_MEMPAGE_W];
                        eng_write_data    <= req_is_write[arb_idx] ?
                            req_wdata[arb_idx*USB_DATA_W +: USB_DATA_W] : '0;
                    end
                end
                ARB_BUSY: begin
                    if (attempt_done) begin
                        eng_read_start  <= 1'b0;
                        eng_write_start <= 1'b0;
                        if (attempt_ok || last_attempt) begin
                            state       <= ARB_RESP;
                            rsp_valid   <= gnt_onehot;
                            rsp_success <= attempt_ok;
                            rsp_rdata   <= (attempt_ok && !lat_write) ? eng_read_data : '0;
                        end else begin
                            state   <= ARB_GAP;
                            attempt <= attempt + ATT_W'(1);
                        end
                    end else begin
                        tcnt <= tcnt_inc;
                    end
                end
                ARB_GAP: begin
                    state           <= ARB_BUSY;
                    tcnt            <= '0;
                    eng_read_start  <= ~lat_write;
                    eng_write_start <= lat_write;
                end
                ARB_RESP: begin
                    state       <= ARB_IDLE;
                    rr_ptr      <= ptr_next;
                    busy        <= 1'b0;
                    rsp_success <= 1'b0;
                    rsp_rdata   <= '0;
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

endmodule
